pong_game_ctrl: RTL and testbench

Game-flow controller for the pong design, sitting between the input/ball logic and the VGA drawing chain. It sequences the match through start screen, serve, play, point pause, user pause and game over. It keeps both scores and drives the ball module's enable, reset and serve direction, using the per-frame tick from the VGA timing path as its time base. All outputs are registered, and the draw modules consume them as steady per-frame state.

---
 rtl/pong_game_ctrl_if.sv | 32 +++
 rtl/pong_game_ctrl.sv | 132 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// pong_game_ctrl_if : event inputs and per-frame game state of the controller
// Rev 1.0
// ----------------------------------------------------------------------------
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic       miss_left;
  logic       miss_right;
  logic       ball_en;
  logic       ball_rst;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [2:0] game_state;
  logic       winner;

  // master: input/ball/VGA side producing events and consuming game state
  modport master (
    output frame_tick, start, pause, miss_left, miss_right,
    input  ball_en, ball_rst, serve_dir, score_l, score_r, game_state, winner
  );

  modport slave (
    input  frame_tick, start, pause, miss_left, miss_right,
    output ball_en, ball_rst, serve_dir, score_l, score_r, game_state, winner
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// pong_game_ctrl : match sequencing, score keeping and ball control for pong
// Rev 1.0
// ----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pong_game_ctrl_if.slave  bus
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_PAUSE = 3'd4,
    S_OVER  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic             serve_dir_q, serve_dir_d;
  logic             start_prev_q, start_ev_q;
  logic             pause_prev_q, pause_ev_q;
  logic             ball_en_q, ball_rst_q, winner_q;
  logic [2:0]       game_state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    if (bus.frame_tick && (state_q == S_SERVE || state_q == S_POINT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_ev_q) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_dir_d = 1'b1;
          state_d     = S_SERVE;
        end
      end
      S_SERVE: begin
        if (bus.frame_tick && cnt_q == SERVE_LAST) state_d = S_PLAY;
      end
      S_PLAY: begin
        // a miss outranks a simultaneous pause event
        if (bus.miss_left && bus.miss_right) begin
          state_d = S_POINT;
        end else if (bus.miss_left) begin
          score_r_d   = score_r_q + 4'd1;
          serve_dir_d = 1'b0;
          state_d     = (score_r_d == WIN) ? S_OVER : S_POINT;
        end else if (bus.miss_right) begin
          score_l_d   = score_l_q + 4'd1;
          serve_dir_d = 1'b1;
          state_d     = (score_l_d == WIN) ? S_OVER : S_POINT;
        end else if (pause_ev_q) begin
          state_d = S_PAUSE;
        end
      end
      S_POINT: begin
        if (bus.frame_tick && cnt_q == POINT_LAST) state_d = S_SERVE;
      end
      S_PAUSE: begin
        if (pause_ev_q) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      serve_dir_q  <= 1'b1;
      start_prev_q <= 1'b0;
      start_ev_q   <= 1'b0;
      pause_prev_q <= 1'b0;
      pause_ev_q   <= 1'b0;
      ball_en_q    <= 1'b0;
      ball_rst_q   <= 1'b1;
      winner_q     <= 1'b0;
      game_state_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_dir_q  <= serve_dir_d;
      start_prev_q <= bus.start;
      start_ev_q   <= bus.start & ~start_prev_q;
      pause_prev_q <= bus.pause;
      pause_ev_q   <= bus.pause & ~pause_prev_q;
      // Moore outputs trail the state register by one cycle
      ball_en_q    <= (state_q == S_PLAY);
      ball_rst_q   <= (state_q == S_IDLE) || (state_q == S_SERVE) || (state_q == S_OVER);
      winner_q     <= (state_q == S_OVER) && (score_r_q == WIN);
      game_state_q <= state_q;
    end
  end

  assign bus.ball_en    = ball_en_q;
  assign bus.ball_rst   = ball_rst_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.game_state = game_state_q;
  assign bus.winner     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pong_game_ctrl : directed scenario bench for the pong game controller
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pong_game_ctrl;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .WIN_SCORE   (3),
    .SERVE_FRAMES(2),
    .POINT_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one frame tick, then one extra cycle so registered outputs settle
  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    cyc(1);
  endtask

  // rise on a button, held long enough that game_state shows the result
  task automatic press(input bit is_pause);
    if (is_pause) bus.pause = 1'b1; else bus.start = 1'b1;
    cyc(3);
    bus.pause = 1'b0;
    bus.start = 1'b0;
    cyc(1);
  endtask

  // miss pulse; returns right after the sampling edge (scores already updated)
  task automatic miss(input bit l, input bit r, input bit with_tick);
    bus.miss_left  = l;
    bus.miss_right = r;
    bus.frame_tick = with_tick;
    cyc(1);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    tests_run++; if (bus.game_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", bus.game_state); end
    tests_run++; if (bus.ball_en !== 1'b0 || bus.ball_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_ball: en=%b rst=%b want en=0 rst=1", bus.ball_en, bus.ball_rst); end
    tests_run++; if (bus.serve_dir !== 1'b1 || bus.winner !== 1'b0) begin tests_failed++; $display("FAIL reset_dir_win: dir=%b win=%b want 1/0", bus.serve_dir, bus.winner); end
    tests_run++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0) begin tests_failed++; $display("FAIL reset_scores: %0d/%0d want 0/0", bus.score_l, bus.score_r); end
  endtask

  task automatic test_start();
    bus.start = 1'b1;
    cyc(2);
    tests_run++; if (bus.game_state !== 3'd0) begin tests_failed++; $display("FAIL start_latency: game_state=%0d want 0 two edges after rise", bus.game_state); end
    cyc(1);
    bus.start = 1'b0;
    tests_run++; if (bus.game_state !== 3'd1 || bus.ball_rst !== 1'b1) begin tests_failed++; $display("FAIL start_serve: state=%0d ball_rst=%b want 1/1", bus.game_state, bus.ball_rst); end
    cyc(1);
    tick();
    tests_run++; if (bus.game_state !== 3'd1) begin tests_failed++; $display("FAIL serve_one_tick: state=%0d want 1", bus.game_state); end
    tick();
    tests_run++; if (bus.game_state !== 3'd2 || bus.ball_en !== 1'b1 || bus.ball_rst !== 1'b0) begin tests_failed++; $display("FAIL serve_to_play: state=%0d en=%b rst=%b want 2/1/0", bus.game_state, bus.ball_en, bus.ball_rst); end
    tests_run++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0) begin tests_failed++; $display("FAIL play_scores: %0d/%0d want 0/0", bus.score_l, bus.score_r); end
  endtask

  task automatic test_point();
    // tick on the entry edge must not count toward the POINT pause
    miss(1'b0, 1'b1, 1'b1);
    tests_run++; if (bus.score_l !== 4'd1 || bus.score_r !== 4'd0 || bus.serve_dir !== 1'b1) begin tests_failed++; $display("FAIL miss_right_score: %0d/%0d dir=%b want 1/0 dir=1", bus.score_l, bus.score_r, bus.serve_dir); end
    tests_run++; if (bus.ball_en !== 1'b1) begin tests_failed++; $display("FAIL ball_en_lag: got %b want 1 on miss edge", bus.ball_en); end
    cyc(1);
    tests_run++; if (bus.game_state !== 3'd3 || bus.ball_en !== 1'b0 || bus.ball_rst !== 1'b0) begin tests_failed++; $display("FAIL point_state: state=%0d en=%b rst=%b want 3/0/0", bus.game_state, bus.ball_en, bus.ball_rst); end
    tick();
    tick();
    tests_run++; if (bus.game_state !== 3'd3) begin tests_failed++; $display("FAIL point_two_ticks: state=%0d want 3", bus.game_state); end
    tick();
    tests_run++; if (bus.game_state !== 3'd1) begin tests_failed++; $display("FAIL point_to_serve: state=%0d want 1", bus.game_state); end
    tick();
    tick();
    tests_run++; if (bus.game_state !== 3'd2) begin tests_failed++; $display("FAIL point_serve_play: state=%0d want 2", bus.game_state); end
  endtask

  task automatic test_double_miss();
    miss(1'b1, 1'b1, 1'b0);
    cyc(1);
    tests_run++; if (bus.score_l !== 4'd1 || bus.score_r !== 4'd0 || bus.serve_dir !== 1'b1 || bus.game_state !== 3'd3) begin tests_failed++; $display("FAIL double_miss: %0d/%0d dir=%b state=%0d want 1/0 dir=1 state=3", bus.score_l, bus.score_r, bus.serve_dir, bus.game_state); end
    repeat (5) tick();
    tests_run++; if (bus.game_state !== 3'd2) begin tests_failed++; $display("FAIL double_miss_resume: state=%0d want 2", bus.game_state); end
  endtask

  task automatic test_pause();
    press(1'b1);
    tests_run++; if (bus.game_state !== 3'd4 || bus.ball_en !== 1'b0) begin tests_failed++; $display("FAIL pause_enter: state=%0d en=%b want 4/0", bus.game_state, bus.ball_en); end
    miss(1'b1, 1'b0, 1'b0);
    cyc(1);
    tests_run++; if (bus.score_r !== 4'd0 || bus.game_state !== 3'd4) begin tests_failed++; $display("FAIL pause_miss_ignored: score_r=%0d state=%0d want 0/4", bus.score_r, bus.game_state); end
    press(1'b1);
    tests_run++; if (bus.game_state !== 3'd2 || bus.ball_en !== 1'b1) begin tests_failed++; $display("FAIL pause_exit: state=%0d en=%b want 2/1", bus.game_state, bus.ball_en); end
    bus.pause = 1'b1;
    cyc(100);
    bus.pause = 1'b0;
    cyc(2);
    tests_run++; if (bus.game_state !== 3'd4) begin tests_failed++; $display("FAIL pause_hold_once: state=%0d want 4", bus.game_state); end
    press(1'b1);
    tests_run++; if (bus.game_state !== 3'd2) begin tests_failed++; $display("FAIL pause_hold_resume: state=%0d want 2", bus.game_state); end
  endtask

  task automatic test_game_over();
    miss(1'b1, 1'b0, 1'b0);
    tests_run++; if (bus.score_r !== 4'd1 || bus.serve_dir !== 1'b0) begin tests_failed++; $display("FAIL miss_left_score: score_r=%0d dir=%b want 1/0", bus.score_r, bus.serve_dir); end
    cyc(1);
    repeat (5) tick();
    miss(1'b1, 1'b0, 1'b0);
    cyc(1);
    repeat (5) tick();
    miss(1'b1, 1'b0, 1'b0);
    cyc(2);
    tests_run++; if (bus.score_r !== 4'd3 || bus.game_state !== 3'd5 || bus.winner !== 1'b1) begin tests_failed++; $display("FAIL game_over: score_r=%0d state=%0d winner=%b want 3/5/1", bus.score_r, bus.game_state, bus.winner); end
    tests_run++; if (bus.ball_rst !== 1'b1 || bus.ball_en !== 1'b0) begin tests_failed++; $display("FAIL over_ball: rst=%b en=%b want 1/0", bus.ball_rst, bus.ball_en); end
    miss(1'b0, 1'b1, 1'b0);
    press(1'b1);
    tests_run++; if (bus.score_l !== 4'd1 || bus.score_r !== 4'd3 || bus.game_state !== 3'd5) begin tests_failed++; $display("FAIL over_ignores: %0d/%0d state=%0d want 1/3 state=5", bus.score_l, bus.score_r, bus.game_state); end
    press(1'b0);
    tests_run++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0 || bus.game_state !== 3'd1 || bus.serve_dir !== 1'b1) begin tests_failed++; $display("FAIL over_restart: %0d/%0d state=%0d dir=%b want 0/0 1 dir=1", bus.score_l, bus.score_r, bus.game_state, bus.serve_dir); end
  endtask

  task automatic test_reset_mid();
    press(1'b1);
    tests_run++; if (bus.game_state !== 3'd1) begin tests_failed++; $display("FAIL serve_pause_ignored: state=%0d want 1", bus.game_state); end
    tick();
    tick();
    miss(1'b0, 1'b1, 1'b0);
    cyc(1);
    repeat (5) tick();
    miss(1'b0, 1'b1, 1'b0);
    cyc(1);
    repeat (5) tick();
    miss(1'b1, 1'b0, 1'b0);
    cyc(1);
    tick();
    tests_run++; if (bus.score_l !== 4'd2 || bus.score_r !== 4'd1 || bus.game_state !== 3'd3) begin tests_failed++; $display("FAIL pre_reset: %0d/%0d state=%0d want 2/1 state=3", bus.score_l, bus.score_r, bus.game_state); end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    tests_run++; if (bus.game_state !== 3'd0 || bus.score_l !== 4'd0 || bus.score_r !== 4'd0 || bus.ball_rst !== 1'b1 || bus.ball_en !== 1'b0 || bus.serve_dir !== 1'b1 || bus.winner !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: state=%0d %0d/%0d brst=%b en=%b dir=%b win=%b want 0 0/0 1 0 1 0", bus.game_state, bus.score_l, bus.score_r, bus.ball_rst, bus.ball_en, bus.serve_dir, bus.winner); end
    press(1'b0);
    tick();
    tests_run++; if (bus.game_state !== 3'd1) begin tests_failed++; $display("FAIL post_reset_count: state=%0d want 1", bus.game_state); end
    tick();
    tests_run++; if (bus.game_state !== 3'd2) begin tests_failed++; $display("FAIL post_reset_play: state=%0d want 2", bus.game_state); end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    test_reset();
    test_start();
    test_point();
    test_double_miss();
    test_pause();
    test_game_over();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
